// File: rtl/scmp_bus_target_if.sv
// SC/MP external bus pins plus the memory-side request/acknowledge port.
// Latency: none; this file only bundles wires.
// Backpressure: mem_ack paces the memory port, and hold_n carries wait states back to the core.
interface scmp_bus_target_if;
  // core side
  logic [11:0] addr_i;
  logic [7:0]  D_i;
  logic        ADS_n;
  logic        RD_n;
  logic        WR_n;
  logic [7:0]  D_o;
  logic        D_oe;
  logic        hold_n;
  // memory side
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  // status
  logic        flag_halt;
  logic        flag_delay;
  logic        flag_fetch;
  logic        flag_read;
  logic        halt_o;
  logic        err_o;

  // the bus target itself
  modport slave (
    input  addr_i, D_i, ADS_n, RD_n, WR_n, mem_ack, mem_rdata,
    output D_o, D_oe, hold_n, mem_addr, mem_wdata, mem_we, mem_req,
    output flag_halt, flag_delay, flag_fetch, flag_read, halt_o, err_o
  );

  // the core pins and the memory, seen from outside the target
  modport master (
    output addr_i, D_i, ADS_n, RD_n, WR_n, mem_ack, mem_rdata,
    input  D_o, D_oe, hold_n, mem_addr, mem_wdata, mem_we, mem_req,
    input  flag_halt, flag_delay, flag_fetch, flag_read, halt_o, err_o
  );
endinterface

// File: rtl/scmp_bus_target.sv
// Bus responder: turns SC/MP ADS_n/RD_n/WR_n strobes into single mem_req/mem_ack transfers.
// Latency: read data is valid 2 edges after the RD_n sample when mem_ack is tied high.
// Backpressure: hold_n stays low while mem_req is outstanding; a transfer is abandoned after TIMEOUT_CYC wait cycles.
module scmp_bus_target #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clk,
  input logic             rst,
  scmp_bus_target_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ADDR, RWAIT, RDRIVE, WWAIT, WDONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  d_o_q, d_o_d;
  logic        d_oe_q, d_oe_d;
  logic        hold_n_q;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  flags_q, flags_d;
  logic        halt_q, halt_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;
  logic        timeout;

  assign cnt_inc = cnt_q + 16'd1;
  assign timeout = (cnt_inc == 16'(TIMEOUT_CYC));

  // Next-state and next-output decode; an address strobe overrides whatever is in flight.
  always_comb begin
    state_d = state_q;
    d_o_d   = d_o_q;
    d_oe_d  = d_oe_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    halt_d  = 1'b0;
    err_d   = 1'b0;

    if (!bus.ADS_n) begin
      // New address phase: abort anything outstanding so a late mem_ack finds no request.
      addr_d  = {bus.D_i[3:0], bus.addr_i};
      flags_d = bus.D_i[7:4];
      halt_d  = bus.D_i[7];
      req_d   = 1'b0;
      d_oe_d  = 1'b0;
      err_d   = !bus.RD_n || !bus.WR_n;
      state_d = ADDR;
    end else begin
      case (state_q)
        ADDR: begin
          if (!bus.RD_n && !bus.WR_n) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (!bus.RD_n) begin
            we_d    = 1'b0;
            req_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = RWAIT;
          end else if (!bus.WR_n) begin
            wdata_d = bus.D_i;
            we_d    = 1'b1;
            req_d   = 1'b1;
            cnt_d   = 16'd0;
            state_d = WWAIT;
          end
        end
        RWAIT: begin
          if (bus.mem_ack) begin
            d_o_d   = bus.mem_rdata;
            d_oe_d  = 1'b1;
            req_d   = 1'b0;
            state_d = RDRIVE;
          end else begin
            cnt_d = cnt_inc;
            if (timeout) begin
              // Abandoned read returns all-ones so the core sees a defined value.
              err_d   = 1'b1;
              req_d   = 1'b0;
              d_o_d   = 8'hFF;
              d_oe_d  = 1'b1;
              state_d = RDRIVE;
            end
          end
        end
        RDRIVE: begin
          if (bus.RD_n) begin
            d_oe_d  = 1'b0;
            state_d = IDLE;
          end
        end
        WWAIT: begin
          if (bus.mem_ack) begin
            req_d   = 1'b0;
            state_d = WDONE;
          end else begin
            cnt_d = cnt_inc;
            if (timeout) begin
              err_d   = 1'b1;
              req_d   = 1'b0;
              state_d = WDONE;
            end
          end
        end
        WDONE: begin
          if (bus.WR_n) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers; hold_n is registered alongside mem_req so the two never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      d_o_q    <= 8'h00;
      d_oe_q   <= 1'b0;
      hold_n_q <= 1'b1;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      flags_q  <= 4'h0;
      halt_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      d_o_q    <= d_o_d;
      d_oe_q   <= d_oe_d;
      hold_n_q <= !req_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      flags_q  <= flags_d;
      halt_q   <= halt_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.D_o        = d_o_q;
  assign bus.D_oe       = d_oe_q;
  assign bus.hold_n     = hold_n_q;
  assign bus.mem_req    = req_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.flag_halt  = flags_q[3];
  assign bus.flag_delay = flags_q[2];
  assign bus.flag_fetch = flags_q[1];
  assign bus.flag_read  = flags_q[0];
  assign bus.halt_o     = halt_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_scmp_bus_target.sv
// Directed bench for scmp_bus_target: vector table plus reset/abort/write-pulse sequences.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: mem_ack is driven per vector to create wait states and timeouts.
module tb_scmp_bus_target;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scmp_bus_target_if bus ();

  scmp_bus_target #(.TIMEOUT_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ads_n;
    logic        rd_n;
    logic        wr_n;
    logic [11:0] addr;
    logic [7:0]  di;
    logic        ack;
    logic [7:0]  rdata;
    logic [5:0]  e_ctl;   // {mem_req, hold_n, mem_we, D_oe, err_o, halt_o}
    logic [3:0]  e_flags; // {halt, delay, fetch, read}
    logic [7:0]  e_do;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [41:0] RESET_OUT = {6'b010000, 4'h0, 8'h00, 16'h0000, 8'h00};

  function automatic logic [41:0] outs();
    return {bus.mem_req, bus.hold_n, bus.mem_we, bus.D_oe, bus.err_o, bus.halt_o,
            bus.flag_halt, bus.flag_delay, bus.flag_fetch, bus.flag_read,
            bus.D_o, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ads_n, input logic rd_n, input logic wr_n,
                       input logic [11:0] addr, input logic [7:0] di,
                       input logic ack, input logic [7:0] rdata);
    bus.ADS_n     = ads_n;
    bus.RD_n      = rd_n;
    bus.WR_n      = wr_n;
    bus.addr_i    = addr;
    bus.D_i       = di;
    bus.mem_ack   = ack;
    bus.mem_rdata = rdata;
  endtask

  task automatic add(input logic ads_n, input logic rd_n, input logic wr_n,
                     input logic [11:0] addr, input logic [7:0] di,
                     input logic ack, input logic [7:0] rdata,
                     input logic [5:0] ctl, input logic [3:0] flags,
                     input logic [7:0] d_o, input logic [15:0] maddr,
                     input logic [7:0] wdata);
    vec_t v;
    v.ads_n = ads_n; v.rd_n = rd_n; v.wr_n = wr_n; v.addr = addr; v.di = di;
    v.ack = ack; v.rdata = rdata; v.e_ctl = ctl; v.e_flags = flags;
    v.e_do = d_o; v.e_addr = maddr; v.e_wdata = wdata;
    vecs.push_back(v);
  endtask

  initial begin
    int req_cycles;

    // Vector table. ctl = {req, hold_n, we, oe, err, halt}.
    // Zero-wait read at 16'hA345, flags fetch+read.
    add(0,1,1,12'h345,8'h3A,1,8'h5C, 6'b010000, 4'h3, 8'h00, 16'hA345, 8'h00);
    add(1,0,1,12'h345,8'h3A,1,8'h5C, 6'b100000, 4'h3, 8'h00, 16'hA345, 8'h00);
    add(1,0,1,12'h345,8'h3A,1,8'h5C, 6'b010100, 4'h3, 8'h5C, 16'hA345, 8'h00);
    add(1,0,1,12'h345,8'h3A,1,8'h5C, 6'b010100, 4'h3, 8'h5C, 16'hA345, 8'h00);
    add(1,1,1,12'h345,8'h3A,1,8'h5C, 6'b010000, 4'h3, 8'h5C, 16'hA345, 8'h00);
    add(1,1,1,12'h345,8'h3A,1,8'h5C, 6'b010000, 4'h3, 8'h5C, 16'hA345, 8'h00);
    // Write to 16'h0010 with ack delayed 3 cycles.
    add(0,1,1,12'h010,8'h00,0,8'h00, 6'b010000, 4'h0, 8'h5C, 16'h0010, 8'h00);
    add(1,1,0,12'h010,8'hC3,0,8'h00, 6'b101000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,0,12'h010,8'hC3,0,8'h00, 6'b101000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,0,12'h010,8'hC3,0,8'h00, 6'b101000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,0,12'h010,8'hC3,0,8'h00, 6'b101000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,0,12'h010,8'hC3,1,8'h00, 6'b011000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,0,12'h010,8'hC3,1,8'h00, 6'b011000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    add(1,1,1,12'h010,8'hC3,1,8'h00, 6'b011000, 4'h0, 8'h5C, 16'h0010, 8'hC3);
    // Read timeout at 16'h20AB: 4 wait cycles, then err + 8'hFF.
    add(0,1,1,12'h0AB,8'h12,0,8'h00, 6'b011000, 4'h1, 8'h5C, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b100000, 4'h1, 8'h5C, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b100000, 4'h1, 8'h5C, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b100000, 4'h1, 8'h5C, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b100000, 4'h1, 8'h5C, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b010110, 4'h1, 8'hFF, 16'h20AB, 8'hC3);
    add(1,0,1,12'h0AB,8'h12,0,8'h00, 6'b010100, 4'h1, 8'hFF, 16'h20AB, 8'hC3);
    add(1,1,1,12'h0AB,8'h12,0,8'h00, 6'b010000, 4'h1, 8'hFF, 16'h20AB, 8'hC3);
    // Halt address phase, then ADS_n with RD_n low (protocol error).
    add(0,1,1,12'h000,8'h80,0,8'h00, 6'b010001, 4'h8, 8'hFF, 16'h0000, 8'hC3);
    add(1,1,1,12'h000,8'h80,0,8'h00, 6'b010000, 4'h8, 8'hFF, 16'h0000, 8'hC3);
    add(0,0,1,12'h123,8'h00,0,8'h00, 6'b010010, 4'h0, 8'hFF, 16'h0123, 8'hC3);
    add(1,1,1,12'h123,8'h00,0,8'h00, 6'b010000, 4'h0, 8'hFF, 16'h0123, 8'hC3);
    // Read aborted by a new ADS_n, late ack ignored.
    add(1,0,1,12'h123,8'h00,0,8'hAA, 6'b100000, 4'h0, 8'hFF, 16'h0123, 8'hC3);
    add(0,1,1,12'h456,8'h05,0,8'hAA, 6'b010000, 4'h0, 8'hFF, 16'h5456, 8'hC3);
    add(1,1,1,12'h456,8'h05,1,8'hAA, 6'b010000, 4'h0, 8'hFF, 16'h5456, 8'hC3);
    add(1,1,1,12'h456,8'h05,1,8'hAA, 6'b010000, 4'h0, 8'hFF, 16'h5456, 8'hC3);
    // RD_n and WR_n both low in ADDR.
    add(1,0,0,12'h456,8'h05,1,8'hAA, 6'b010010, 4'h0, 8'hFF, 16'h5456, 8'hC3);
    add(1,1,1,12'h456,8'h05,1,8'hAA, 6'b010000, 4'h0, 8'hFF, 16'h5456, 8'hC3);

    // Power-on reset, then random traffic, then reset mid-traffic.
    rst = 1'b1;
    drive(1,1,1,12'h000,8'h00,0,8'h00);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
            12'($urandom), 8'($urandom), 1'($urandom_range(0,1)), 8'($urandom));
      tick();
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset_edge%0d", i), 64'(outs()), 64'(RESET_OUT));
      drive(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
            12'($urandom), 8'($urandom), 1'($urandom_range(0,1)), 8'($urandom));
    end
    drive(1,1,1,12'h000,8'h00,0,8'h00);
    tick();
    rst = 1'b0;
    tick();
    check("reset_idle", 64'(outs()), 64'(RESET_OUT));

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].ads_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].addr,
            vecs[i].di, vecs[i].ack, vecs[i].rdata);
      tick();
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].e_ctl, vecs[i].e_flags, vecs[i].e_do, vecs[i].e_addr, vecs[i].e_wdata}));
    end

    // Reset during RWAIT drops mem_req at that edge; a later ack does nothing.
    drive(0,1,1,12'h777,8'h0F,0,8'h00);
    tick();
    drive(1,0,1,12'h777,8'h0F,0,8'h00);
    tick();
    check("abort_req_up", 64'({bus.mem_req, bus.hold_n}), 64'(2'b10));
    rst = 1'b1;
    tick();
    check("abort_reset", 64'(outs()), 64'(RESET_OUT));
    rst = 1'b0;
    drive(1,0,1,12'h777,8'h0F,1,8'h11);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("late_ack%0d", i), 64'({bus.mem_req, bus.D_oe, bus.D_o}), 64'({2'b00, 8'h00}));
    end
    drive(1,1,1,12'h777,8'h0F,0,8'h00);
    tick();

    // Zero-wait write: mem_req high for exactly one cycle.
    drive(0,1,1,12'h0FF,8'h00,1,8'h00);
    tick();
    drive(1,1,0,12'h0FF,8'h5A,1,8'h00);
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.mem_req) req_cycles++;
    end
    check("wr_req_cycles", 64'(req_cycles), 64'd1);
    check("wr_latched", 64'({bus.mem_we, bus.mem_wdata, bus.mem_addr}), 64'({1'b1, 8'h5A, 16'h00FF}));
    drive(1,1,1,12'h0FF,8'h00,0,8'h00);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scmp_bus_target.md
# scmp_bus_target

Bus-side responder for the SC/MP core's external bus. It latches the 16-bit address and cycle status flags multiplexed on the data bus during the ADS_n strobe. It converts each RD_n/WR_n strobe into a single request/acknowledge transfer on a memory-side port, drives read data back onto the core's data bus, and signals wait states and protocol/timeout errors. It sits between the core pins (addr, D_o, D_i, ADS_n, RD_n, WR_n) and on-chip RAM/peripheral decode.

## Interface
- TIMEOUT_CYC, 255: wait-state cycles without mem_ack before a transfer is abandoned; legal range 1..65535.
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- addr_i  in  12  core address (addr[11:0])
- D_i  in  8  core data bus out; {H,D,I,R,addr[15:12]} during ADS_n low, write data during WR_n low
- ADS_n  in  1  address strobe, active low
- RD_n  in  1  read strobe, active low
- WR_n  in  1  write strobe, active low
- D_o  out  8  read data to core
- D_oe  out  1  D_o valid/drive enable
- hold_n  out  1  wait request to core, low while a memory transfer is outstanding
- mem_addr  out  16  latched address {D_i[3:0], addr_i}
- mem_wdata  out  8  latched write data
- mem_we  out  1  1 = write transfer, 0 = read; valid while mem_req
- mem_req  out  1  transfer request, level, held until accepted
- mem_ack  in  1  transfer accept; completion on an edge where mem_req && mem_ack
- mem_rdata  in  8  read data, sampled on the completing edge
- flag_halt, flag_delay, flag_fetch, flag_read  out  1 each  D_i[7:4] latched at address phase
- halt_o  out  1  one-cycle pulse when an address phase with H=1 is latched
- err_o  out  1  one-cycle pulse on protocol error or timeout

## Operation
- States: IDLE, ADDR, RWAIT, RDRIVE, WWAIT, WDONE.
- Reset: state IDLE; D_o=0, D_oe=0, hold_n=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all flags 0, halt_o=0, err_o=0, timeout counter 0.
- In any state, when ADS_n is sampled low:
  - Latch mem_addr={D_i[3:0],addr_i} and flags=D_i[7:4]; go to ADDR.
  - halt_o=1 for that cycle if D_i[7]=1.
  - An outstanding mem_req is dropped; this is an abort, and a late mem_ack is ignored.
  - D_oe clears.
- ADS_n low together with RD_n or WR_n low: latch the address, ignore the strobes, pulse err_o.
- ADDR:
  - RD_n low: mem_we=0, mem_req=1, go to RWAIT.
  - WR_n low: mem_wdata=D_i, mem_we=1, mem_req=1, go to WWAIT.
  - RD_n and WR_n both low: pulse err_o, go to IDLE.
- RWAIT, on mem_ack: D_o=mem_rdata, D_oe=1, mem_req=0, go to RDRIVE.
- RDRIVE: hold D_o and D_oe while RD_n is low; when RD_n is sampled high, D_oe=0 and go to IDLE. D_o keeps its last value.
- WWAIT, on mem_ack: mem_req=0, go to WDONE. WDONE goes to IDLE when WR_n is sampled high.
- hold_n = !mem_req, registered together with mem_req.
- Timeout:
  - The 16-bit counter clears on entry to RWAIT/WWAIT and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYC, pulse err_o and drop mem_req.
  - A read then drives D_o=8'hFF, D_oe=1 and goes to RDRIVE; a write goes to WDONE.
- mem_addr, mem_we and mem_wdata are stable from mem_req rising until completion.
- Exactly one memory transfer per strobe. A strobe held low for many cycles never re-issues.

## Timing
- Edge E0 samples RD_n low in ADDR: mem_req=1 and hold_n=0 after E0.
- With mem_ack tied high, completion is at E1 and D_o/D_oe are valid after E1. Read latency is 2 edges from the strobe sample.
- Each cycle of mem_ack low adds one cycle of hold_n low and latency.
- Write with ack tied high: mem_req high for exactly one cycle.
- D_oe falls one edge after RD_n is sampled high.
- err_o and halt_o are single-cycle pulses, never stretched.
- A rising-edge rst mid-transfer returns all outputs to reset values at that edge. A mem_ack after reset has no effect.

## Test plan
- Reset: assert rst 2 cycles mid-random traffic -> all outputs at reset values, hold_n=1, state IDLE.
- Zero-wait read: ADS_n low with addr_i=12'h345, D_i=8'h3A, then RD_n low; mem_ack=1, mem_rdata=8'h5C -> mem_addr=16'hA345, flag_fetch=1, flag_read=1, hold_n low 1 cycle, D_o=8'h5C with D_oe=1 two edges after the RD_n sample; RD_n high -> D_oe=0 next edge.
- Waited write: address 16'h0010, WR_n low with D_i=8'hC3, mem_ack delayed 3 cycles -> mem_we=1, mem_wdata=8'hC3, mem_req/hold_n active 4 cycles, single completion, back to IDLE after WR_n high.
- Timeout: TIMEOUT_CYC=4, read with mem_ack held 0 -> err_o pulses once after 4 wait cycles, mem_req drops, D_o=8'hFF, D_oe=1.
- Halt/protocol: D_i=8'h80 at ADS_n -> halt_o pulses one cycle, flag_halt=1; ADS_n and RD_n low together -> err_o pulse, no mem_req.
- Abort: reset or new ADS_n during RWAIT -> mem_req=0 at that edge; mem_ack asserted afterwards -> no D_oe, no state change.
